shift_seq: RTL

Sequential 16-bit shift/rotate engine for the execute stage, sitting directly upstream of the writeback mux and alongside the combinational rotate path. It accepts an operand, a 4-bit count and one of four operations (ROL, SLL, ROR, SRL), then applies the shift as four binary-weighted stages, one per clock, with a start/busy/done handshake. The result is held on `Out` until the next accepted start, so the control unit can stall on `busy` and capture the result on `done`.

---
 rtl/shift_pkg.sv | 29 ++
 rtl/shift_stage.sv | 32 +++
 rtl/shift_seq.sv | 81 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the sequential shift/rotate engine.
// Optional feature macro used by shift_seq: SHIFT_EARLY_EXIT_EN.
package shift_pkg;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
  localparam int KW     = $clog2(STAGES);
  localparam int AW     = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Operation parameters latched at accept time.
  typedef struct packed {
    op_e               op;
    logic [STAGES-1:0] cnt;
  } ctrl_t;

endpackage

// File: rtl/shift_stage.sv
// One binary-weighted shift/rotate stage: moves data by 2^k when enabled,
// otherwise passes it through. Purely combinational.
module shift_stage
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] data_i,
  input  op_e              op_i,
  input  logic [KW-1:0]    k_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o
);

  logic [AW-1:0] amt;
  logic [AW-1:0] rem;

  always_comb begin
    amt    = AW'(1) << k_i;
    // Rotates are built from the two complementary logical shifts.
    rem    = AW'(WIDTH) - amt;
    data_o = data_i;
    if (en_i) begin
      unique case (op_i)
        OP_ROL: data_o = (data_i << amt) | (data_i >> rem);
        OP_SLL: data_o = data_i << amt;
        OP_ROR: data_o = (data_i >> amt) | (data_i << rem);
        OP_SRL: data_o = data_i >> amt;
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Sequential 16-bit shift/rotate engine with start/busy/done handshake.
// Define SHIFT_EARLY_EXIT_EN to let a zero count skip the shift stages.
module shift_seq
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  in,
  input  logic [STAGES-1:0] bit_cnt,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  Out
);

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] data_q, data_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [WIDTH-1:0] stage_out;

  shift_stage u_stage (
    .data_i (data_q),
    .op_i   (ctrl_q.op),
    .k_i    (k_q),
    .en_i   (ctrl_q.cnt[k_q]),
    .data_o (stage_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          data_d     = in;
          ctrl_d.op  = op_e'(op);
          ctrl_d.cnt = bit_cnt;
          k_d        = '0;
`ifdef SHIFT_EARLY_EXIT_EN
          if (bit_cnt == '0) state_d = ST_DONE;
          else               state_d = ST_SHIFT;
`else
          state_d    = ST_SHIFT;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // start is deliberately not looked at here; the captured op runs to completion.
        data_d = stage_out;
        k_d    = k_q + 1'b1;
        if (k_q == KW'(STAGES - 1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign Out  = data_q;

endmodule
